reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Turns the raw master reset (_mr) and a synchronous soft-reset
//            request (_soft_rst) into a clean active-low downstream reset
//            (_rd_out). The reset asserts asynchronously and releases
//            synchronously after a hold period. The block then produces the
//            fetch/execute phase toggle and a ready flag.
// Ports    : clk        in   system clock, rising edge
//            _mr        in   master reset, asynchronous, active-low
//            _soft_rst  in   soft-reset request, active-low, sampled on clk
//            kick       in   watchdog kick, active-high, sampled on clk
//            _rd_out    out  active-low reset to downstream flops
//            phase      out  fetch/execute phase, toggles every RUN cycle
//            ready      out  high only in RUN
//            state      out  ASSERT=00 HOLD=01 RELEASE=10 RUN=11
//            wdog_fired out  sticky: watchdog has fired since the last _mr
// Options  : RESET_SEQUENCER_WDOG_EN - builds the RUN-state watchdog. When
//            the macro is undefined, kick is ignored and wdog_fired is 0.
// Notes    : Every output comes straight from a flop. PROP_DELAY and LOG
//            describe the behavioural model's output delay and trace. This
//            synthesizable view has no modelled delay and no trace, so
//            output timing is the flop clock-to-q.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int HOLD_CYCLES = 8,
  parameter int WDOG_CYCLES = 1024,
  parameter int PROP_DELAY  = 10,
  parameter int LOG         = 0
) (
  input  logic       clk,
  input  logic       _mr,
  input  logic       _soft_rst,
  input  logic       kick,
  output logic       _rd_out,
  output logic       phase,
  output logic       ready,
  output logic [1:0] state,
  output logic       wdog_fired
);

  localparam int                c_cnt_w     = $clog2(HOLD_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);

  // Configuration values that only the behavioural model consumes.
  localparam bit c_unused_cfg = (PROP_DELAY != 0) ^ (LOG != 0) ^ (WDOG_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_HOLD    = 2'b01,
    ST_RELEASE = 2'b10,
    ST_RUN     = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q, sync_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               rd_n_q, rd_n_d;
  logic               phase_q, phase_d;
  logic               ready_q, ready_d;
  logic               wdog_expire;
  logic               go_hold;

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef RESET_SEQUENCER_WDOG_EN
  localparam int                 c_wcnt_w    = $clog2(WDOG_CYCLES);
  localparam logic [c_wcnt_w-1:0] c_wcnt_last = c_wcnt_w'(WDOG_CYCLES - 1);

  logic [c_wcnt_w-1:0] wcnt_q, wcnt_d;
  logic                wdog_fired_q, wdog_fired_d;

  // The counter sits at zero outside RUN, so it always starts from zero on
  // RUN entry. A kick on the expiry edge clears it and suppresses the fire.
  always_comb begin
    wcnt_d      = wcnt_q;
    wdog_expire = 1'b0;
    if (state_q != ST_RUN) begin
      wcnt_d = '0;
    end else if (kick) begin
      wcnt_d = '0;
    end else if (wcnt_q == c_wcnt_last) begin
      wdog_expire = 1'b1;
      wcnt_d      = '0;
    end else begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  // A soft reset on the same edge outranks expiry, so the flag is not set.
  always_comb begin
    wdog_fired_d = wdog_fired_q | (wdog_expire & _soft_rst);
  end

  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      wcnt_q       <= '0;
      wdog_fired_q <= 1'b0;
    end else begin
      wcnt_q       <= wcnt_d;
      wdog_fired_q <= wdog_fired_d;
    end
  end

  assign wdog_fired = wdog_fired_q;
`else
  logic unused_kick;
  assign unused_kick = kick;
  assign wdog_expire = 1'b0;
  assign wdog_fired  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sequencer next-state logic
  // --------------------------------------------------------------------------
  // Soft reset and watchdog expiry share one entry path into HOLD. ASSERT
  // ignores both because the sync chain is still in progress.
  assign go_hold = (state_q != ST_ASSERT) && (!_soft_rst || wdog_expire);

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], 1'b1};
    cnt_d   = cnt_q;
    rd_n_d  = rd_n_q;
    phase_d = phase_q;
    ready_d = ready_q;

    if (go_hold) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      rd_n_d  = 1'b0;
      ready_d = 1'b0;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rd_n_d  = 1'b0;
          ready_d = 1'b0;
          phase_d = 1'b0;
          // Stage 2 of the synchroniser goes high on this edge.
          if (sync_q == 2'b01) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == c_hold_last) begin
            state_d = ST_RELEASE;
            rd_n_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
        ST_RUN: begin
          phase_d = ~phase_q;
        end
        default: begin
          state_d = ST_ASSERT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer registers. _mr clears everything with no clock needed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      state_q <= ST_ASSERT;
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      rd_n_q  <= 1'b0;
      phase_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      rd_n_q  <= rd_n_d;
      phase_q <= phase_d;
      ready_q <= ready_d;
    end
  end

  assign _rd_out = rd_n_q;
  assign phase   = phase_q;
  assign ready   = ready_q;
  assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Directed self-checking bench for reset_sequencer
//            (HOLD_CYCLES=8, WDOG_CYCLES=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  localparam int H = 8;
  localparam int W = 16;

  logic       clk    = 1'b0;
  logic       mr_n   = 1'b0;
  logic       soft_n = 1'b1;
  logic       kick   = 1'b0;
  logic       rd_out_n;
  logic       phase;
  logic       ready;
  logic [1:0] state;
  logic       wdog_fired;
  logic [5:0] obs;

  int checks   = 0;
  int failures = 0;

  assign obs = {state, rd_out_n, ready, phase, wdog_fired};

  always #5 clk = ~clk;

  reset_sequencer #(
    .HOLD_CYCLES(H),
    .WDOG_CYCLES(W),
    .PROP_DELAY (10),
    .LOG        (0)
  ) dut (
    .clk       (clk),
    ._mr       (mr_n),
    ._soft_rst (soft_n),
    .kick      (kick),
    ._rd_out   (rd_out_n),
    .phase     (phase),
    .ready     (ready),
    .state     (state),
    .wdog_fired(wdog_fired)
  );

  // Expected {state, _rd_out, ready, phase, wdog_fired}.
  // j counts edges since the edge on which HOLD was entered (j=0).
  function automatic logic [5:0] exp_hold(input int j, input logic wd);
    if (j < H)  return {2'b01, 1'b0, 1'b0, 1'b0, wd};
    if (j == H) return {2'b10, 1'b1, 1'b0, 1'b0, wd};
    return {2'b11, 1'b1, 1'b1, (j > H + 1) && (((j - H - 1) % 2) == 1), wd};
  endfunction

  // k counts edges after _mr rises mid-cycle; HOLD is entered at edge 2.
  function automatic logic [5:0] exp_power(input int k);
    if (k < 2) return 6'b000000;
    return exp_hold(k - 2, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mr_n   = 1'b0;
    soft_n = 1'b1;
    kick   = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs !== 6'b000000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs, 6'b000000);
    end
  endtask

  task automatic test_power_on();
    #4 mr_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      checks++;
      if (obs !== exp_power(k)) begin
        failures++;
        $display("FAIL power_on edge=%0d got=%b exp=%b", k, obs, exp_power(k));
      end
    end
  endtask

  task automatic test_soft_pulse();
    soft_n = 1'b0;
    tick();
    soft_n = 1'b1;
    for (int k = 0; k <= H + 3; k++) begin
      if (k > 0) tick();
      checks++;
      if (obs !== exp_hold(k, 1'b0)) begin
        failures++;
        $display("FAIL soft_pulse edge=n+%0d got=%b exp=%b", k, obs, exp_hold(k, 1'b0));
      end
    end
  endtask

  // Variant 0: low for edges n..n+4. Variant 1: additionally low at n+7.
  task automatic test_soft_held();
    for (int v = 0; v < 2; v++) begin
      int j;
      j = 0;
      for (int k = 0; k <= 17; k++) begin
        soft_n = !((k <= 4) || (v == 1 && k == 7));
        tick();
        if (!soft_n) j = 0;
        else         j++;
        checks++;
        if (obs !== exp_hold(j, 1'b0)) begin
          failures++;
          $display("FAIL soft_held v=%0d edge=n+%0d got=%b exp=%b", v, k, obs, exp_hold(j, 1'b0));
        end
      end
      soft_n = 1'b1;
    end
  endtask

`ifdef RESET_SEQUENCER_WDOG_EN
  task automatic test_watchdog();
    logic [5:0] e;
    // No kick: RUN is entered at n+9, so the 16th RUN edge is n+25.
    soft_n = 1'b0;
    tick();
    soft_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k < 9 + W)       e = exp_hold(k, 1'b0);
      else if (k == 9 + W) e = exp_hold(0, 1'b1);
      else                 e = exp_hold(k - 9 - W, 1'b1);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL wdog_nokick edge=n+%0d got=%b exp=%b", k, obs, e);
      end
    end
    // Kick every 10 RUN cycles: never fires, sticky flag stays set.
    soft_n = 1'b0;
    tick();
    soft_n = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      kick = (k > 9) && (((k - 9) % 10) == 0);
      tick();
      checks++;
      if (obs !== exp_hold(k, 1'b1)) begin
        failures++;
        $display("FAIL wdog_kick10 edge=n+%0d got=%b exp=%b", k, obs, exp_hold(k, 1'b1));
      end
    end
    kick = 1'b0;
    // Kick exactly on the expiry edge: kick wins.
    soft_n = 1'b0;
    tick();
    soft_n = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      kick = (k == 9 + W);
      tick();
      checks++;
      if (obs !== exp_hold(k, 1'b1)) begin
        failures++;
        $display("FAIL wdog_kick_edge edge=n+%0d got=%b exp=%b", k, obs, exp_hold(k, 1'b1));
      end
    end
    kick = 1'b0;
  endtask
`else
  task automatic test_no_wdog();
    soft_n = 1'b0;
    tick();
    soft_n = 1'b1;
    for (int k = 1; k <= 109; k++) begin
      tick();
      checks++;
      if (obs !== exp_hold(k, 1'b0)) begin
        failures++;
        $display("FAIL no_wdog edge=n+%0d got=%b exp=%b", k, obs, exp_hold(k, 1'b0));
      end
    end
  endtask
`endif

  // 3 ns _mr pulse between edges: outputs clear with no clock edge, and the
  // full power-on sequence follows.
  task automatic test_async_clear();
    mr_n = 1'b0;
    #2;
    checks++;
    if (obs !== 6'b000000) begin
      failures++;
      $display("FAIL async_clear got=%b exp=%b", obs, 6'b000000);
    end
    #1 mr_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      checks++;
      if (obs !== exp_power(k)) begin
        failures++;
        $display("FAIL async_restart edge=%0d got=%b exp=%b", k, obs, exp_power(k));
      end
    end
  endtask

  // Soft pulse landing on the first edge of ASSERT must be ignored.
  task automatic test_soft_in_assert();
    mr_n = 1'b0;
    #3 mr_n = 1'b1;
    soft_n = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      soft_n = 1'b1;
      checks++;
      if (obs !== exp_power(k)) begin
        failures++;
        $display("FAIL soft_in_assert edge=%0d got=%b exp=%b", k, obs, exp_power(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_soft_pulse();
    test_soft_held();
`ifdef RESET_SEQUENCER_WDOG_EN
    test_watchdog();
`else
    test_no_wdog();
`endif
    test_async_clear();
    test_soft_in_assert();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
